load_align_unit: RTL and testbench
==================================

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter: WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  load request present this cycle.
REQ-005 req_ready  output  1  unit accepts the request this cycle; a request is accepted when req_valid && req_ready && !flush.
REQ-006 req_funct3  input  3  RV32I load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-007 req_addr  input  32  byte address from the ALU.
REQ-008 req_rd  input  5  destination register tag.
REQ-009 flush  input  1  abort any in-flight load.
REQ-010 dmem_en  output  1  synchronous-read enable to data memory; read data returns on dmem_dout the following cycle.
REQ-011 dmem_addr  output  32  word-aligned byte address (bits [1:0] always 00).
REQ-012 dmem_dout  input  32  memory read data, valid the cycle after dmem_en.
REQ-013 wb_valid  output  1  registered one-cycle pulse: result ready.
REQ-014 wb_data  output  32  aligned, extended load result.
REQ-015 wb_rd  output  5  tag of the completing load.
REQ-016 wb_err  output  1  asserted with wb_valid for an unsupported funct3.

Function
REQ-017 FSM states: IDLE, BEAT1, BEAT2. Per-request latched context: funct3, offset = addr[1:0], rd, word address, misaligned flag.
REQ-018 misaligned = (LH/LHU with offset == 3) or (LW with offset != 0); byte loads are never misaligned.
REQ-019 Unsupported funct3 (011, 110, 111) is accepted and performs one beat with dmem_en = 1. The result is wb_data = 0 and wb_err = 1.
REQ-020 req_ready = (state == IDLE) or (state == BEAT1 and latched request not misaligned).
REQ-021 On accept, dmem_en = 1 and dmem_addr = {req_addr[31:2], 2'b00} combinationally in the same cycle; the next state is BEAT1.
REQ-022 BEAT1, aligned case: capture dmem_dout as the low word. Drive wb_valid, wb_data, wb_rd and wb_err on the next edge. The next state is BEAT1 if a new request is accepted this cycle, otherwise IDLE.
REQ-023 BEAT1, misaligned case: capture the low word. Issue dmem_en = 1 with dmem_addr = latched word address + 4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000). The next state is BEAT2.
REQ-024 BEAT2: capture dmem_dout as the high word, drive the wb outputs on the next edge, and go to IDLE. req_ready = 0 in this state.
REQ-025 Extraction: form {hi, lo} with hi = 0 for aligned loads, then shift right by 8*offset. The low byte, low half, or low word is selected by funct3.
REQ-026 Sign handling: LB and LH sign-extend from bit 7 and bit 15 respectively; LBU and LHU zero-extend.
REQ-027 Latency: an aligned request accepted at cycle T gives wb_valid at T+2; a misaligned request gives wb_valid at T+3.
REQ-028 Throughput: aligned loads can be accepted back-to-back, one per cycle. Misaligned loads occupy the unit for 2 accept slots.
REQ-029 wb_valid is high for exactly one cycle per completed load. wb_data, wb_rd and wb_err hold their last values while wb_valid = 0.
REQ-030 When state == IDLE and no request is accepted, dmem_en = 0 and dmem_addr = 0.
REQ-031 flush high in any cycle:
- the next state is IDLE;
- no wb_valid is produced for any in-flight load, including one whose wb_valid would have asserted on this edge;
- a same-cycle req_valid is dropped (flush wins);
- dmem_en = 0 in that cycle.
REQ-032 flush in IDLE with no request has no effect.

Reset
REQ-033 On a clk edge with rst = 1: state = IDLE, wb_valid = 0, wb_data = 0, wb_rd = 0, wb_err = 0, and all latched context = 0.
REQ-034 While rst = 1: req_ready = 0 and dmem_en = 0. rst overrides flush and req_valid.
REQ-035 rst asserted mid-operation (BEAT1 or BEAT2) discards the load; no wb_valid follows.

Verification
REQ-036 Aligned LB: addr 0x1002, dmem_dout 0x80FF7F01 -> at T+2, wb_valid = 1 and wb_data = 0xFFFFFFFF; with LBU, wb_data = 0x000000FF.
REQ-037 Misaligned LW: addr 0x2001, words 0x44332211 @0x2000 and 0x88776655 @0x2004 -> dmem_addr 0x2000 then 0x2004; at T+3, wb_data = 0x55443322.
REQ-038 Misaligned LH: addr 0xFFFFFFFF, lo word 0x80xxxxxx, hi word 0xxxxxxx7F -> second dmem_addr = 0x00000000 and wb_data = 0x00007F80.
REQ-039 Back-to-back aligned: LW @0x10 tag 5 at T, LHU @0x16 tag 6 at T+1, data 0xDEADBEEF then 0xCAFEF00D -> wb 0xDEADBEEF/rd 5 at T+2, wb 0x0000CAFE/rd 6 at T+3.
REQ-040 Flush in BEAT2 of a misaligned LW and funct3 = 011 request -> flush: no wb_valid, state IDLE, req_ready = 1 next cycle; funct3 011: wb_valid with wb_err = 1 and wb_data = 0.
REQ-041 rst asserted in BEAT1 -> next cycle all outputs are 0 and no wb_valid for the aborted load.

Source files
------------

// File: rtl/load_align_if.sv
// Load request, data-memory and writeback signals for load_align_unit.
// The master side issues requests and models the memory; the slave side is the unit.
interface load_align_if #(parameter int WIDTH = 32);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_funct3;
   logic [WIDTH-1:0] req_addr;
   logic [4:0]       req_rd;
   logic             flush;
   logic             dmem_en;
   logic [WIDTH-1:0] dmem_addr;
   logic [WIDTH-1:0] dmem_dout;
   logic             wb_valid;
   logic [WIDTH-1:0] wb_data;
   logic [4:0]       wb_rd;
   logic             wb_err;

   modport master (
      output req_valid, req_funct3, req_addr, req_rd, flush, dmem_dout,
      input  req_ready, dmem_en, dmem_addr, wb_valid, wb_data, wb_rd, wb_err
   );

   modport slave (
      input  req_valid, req_funct3, req_addr, req_rd, flush, dmem_dout,
      output req_ready, dmem_en, dmem_addr, wb_valid, wb_data, wb_rd, wb_err
   );
endinterface

// File: rtl/load_align_unit.sv
// RV32I load alignment unit: fetches one or two memory words per load, then
// aligns and sign/zero-extends the result into a registered writeback pulse.
//
// state | meaning
// IDLE  | no load in flight
// BEAT1 | first word returning; aligned loads complete here
// BEAT2 | second word of a misaligned load returning
module load_align_unit #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   load_align_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

   state_t           state, state_nxt;
   logic [2:0]       ctx_funct3;
   logic [1:0]       ctx_off;
   logic [4:0]       ctx_rd;
   logic [WIDTH-3:0] ctx_waddr;
   logic             ctx_mis;
   logic [WIDTH-1:0] lo_word;

   logic             accept;
   logic             req_mis;
   logic             wb_fire;
   logic [WIDTH-1:0] hi_sel, lo_sel, shifted, load_data;
   logic             load_err;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = accept ? BEAT1 : IDLE;
            BEAT1:   state_nxt = ctx_mis ? BEAT2 : (accept ? BEAT1 : IDLE);
            BEAT2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.req_ready = !rst && (state == IDLE || (state == BEAT1 && !ctx_mis));
      accept        = bus.req_valid && bus.req_ready && !bus.flush;
      bus.dmem_en   = 1'b0;
      bus.dmem_addr = '0;
      wb_fire       = !rst && !bus.flush && ((state == BEAT1 && !ctx_mis) || state == BEAT2);
      // The second beat of a misaligned load owns the memory port over any new request.
      if (!rst && !bus.flush) begin
         if (state == BEAT1 && ctx_mis) begin
            bus.dmem_en   = 1'b1;
            bus.dmem_addr = {ctx_waddr + {{(WIDTH-3){1'b0}}, 1'b1}, 2'b00};
         end else if (accept) begin
            bus.dmem_en   = 1'b1;
            bus.dmem_addr = {bus.req_addr[WIDTH-1:2], 2'b00};
         end
      end
   end

   always_comb begin
      req_mis = 1'b0;
      case (bus.req_funct3)
         3'b001, 3'b101: req_mis = (bus.req_addr[1:0] == 2'd3);
         3'b010:         req_mis = (bus.req_addr[1:0] != 2'd0);
         default:        req_mis = 1'b0;
      endcase
   end

   always_comb begin
      lo_sel    = (state == BEAT2) ? lo_word : bus.dmem_dout;
      hi_sel    = (state == BEAT2) ? bus.dmem_dout : '0;
      shifted   = WIDTH'({hi_sel, lo_sel} >> {ctx_off, 3'b000});
      load_data = '0;
      load_err  = 1'b0;
      case (ctx_funct3)
         3'b000:  load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = shifted;
         3'b100:  load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
         3'b101:  load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
         default: load_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.wb_valid <= 1'b0;
         bus.wb_data  <= '0;
         bus.wb_rd    <= '0;
         bus.wb_err   <= 1'b0;
         ctx_funct3   <= '0;
         ctx_off      <= '0;
         ctx_rd       <= '0;
         ctx_waddr    <= '0;
         ctx_mis      <= 1'b0;
         lo_word      <= '0;
      end else begin
         bus.wb_valid <= wb_fire;
         if (wb_fire) begin
            bus.wb_data <= load_data;
            bus.wb_rd   <= ctx_rd;
            bus.wb_err  <= load_err;
         end
         if (state == BEAT1 && ctx_mis) lo_word <= bus.dmem_dout;
         if (accept) begin
            ctx_funct3 <= bus.req_funct3;
            ctx_off    <= bus.req_addr[1:0];
            ctx_rd     <= bus.req_rd;
            ctx_waddr  <= bus.req_addr[WIDTH-1:2];
            ctx_mis    <= req_mis;
         end
      end
   end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: inputs change on the falling edge,
// outputs are checked 1 ns later, expected values are hand-computed.
module tb_load_align_unit;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   load_align_if #(.WIDTH(32)) bus ();

   load_align_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                        input logic [4:0] rd, input logic fl, input logic [31:0] dout);
      bus.req_valid  = v;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_rd     = rd;
      bus.flush      = fl;
      bus.dmem_dout  = dout;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 3'b010, 32'h0000_1000, 5'd1, 1'b1, 32'h0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_dmem_en", bus.dmem_en, 0);
      next_cycle();
      drive(1'b1, 3'b010, 32'h0000_1000, 5'd1, 1'b0, 32'h0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_wb_data", bus.wb_data, 0);
      chk("rst_wb_rd", bus.wb_rd, 0);
      chk("rst_wb_err", bus.wb_err, 0);
      next_cycle();
      rst = 1'b0;

      // idle flush with no request has no effect
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 32'h0);
      chk("idle_dmem_en", bus.dmem_en, 0);
      chk("idle_dmem_addr", bus.dmem_addr, 0);
      next_cycle();

      // aligned LB at 0x1002
      drive(1'b1, 3'b000, 32'h0000_1002, 5'd3, 1'b0, 32'h0);
      chk("lb_ready", bus.req_ready, 1);
      chk("lb_dmem_en", bus.dmem_en, 1);
      chk("lb_dmem_addr", bus.dmem_addr, 32'h0000_1000);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h80FF_7F01);
      chk("lb_t1_wb_valid", bus.wb_valid, 0);
      chk("lb_t1_ready", bus.req_ready, 1);
      chk("lb_t1_dmem_en", bus.dmem_en, 0);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("lb_wb_valid", bus.wb_valid, 1);
      chk("lb_wb_data", bus.wb_data, 32'hFFFF_FFFF);
      chk("lb_wb_rd", bus.wb_rd, 3);
      chk("lb_wb_err", bus.wb_err, 0);
      next_cycle();

      // aligned LBU at 0x1002
      drive(1'b1, 3'b100, 32'h0000_1002, 5'd4, 1'b0, 32'h0);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h80FF_7F01);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("lbu_wb_valid", bus.wb_valid, 1);
      chk("lbu_wb_data", bus.wb_data, 32'h0000_00FF);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("lbu_pulse_end", bus.wb_valid, 0);
      chk("lbu_hold_data", bus.wb_data, 32'h0000_00FF);
      chk("lbu_hold_rd", bus.wb_rd, 4);
      next_cycle();

      // misaligned LW at 0x2001
      drive(1'b1, 3'b010, 32'h0000_2001, 5'd7, 1'b0, 32'h0);
      chk("lw_mis_addr0", bus.dmem_addr, 32'h0000_2000);
      next_cycle();
      drive(1'b1, 3'b000, 32'h0000_0100, 5'd8, 1'b0, 32'h4433_2211);
      chk("lw_mis_ready_b1", bus.req_ready, 0);
      chk("lw_mis_en1", bus.dmem_en, 1);
      chk("lw_mis_addr1", bus.dmem_addr, 32'h0000_2004);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h8877_6655);
      chk("lw_mis_ready_b2", bus.req_ready, 0);
      chk("lw_mis_en_b2", bus.dmem_en, 0);
      chk("lw_mis_t2_valid", bus.wb_valid, 0);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("lw_mis_wb_valid", bus.wb_valid, 1);
      chk("lw_mis_wb_data", bus.wb_data, 32'h5544_3322);
      chk("lw_mis_wb_rd", bus.wb_rd, 7);
      next_cycle();

      // misaligned LH at 0xFFFFFFFF wraps to word 0
      drive(1'b1, 3'b001, 32'hFFFF_FFFF, 5'd9, 1'b0, 32'h0);
      chk("lh_wrap_addr0", bus.dmem_addr, 32'hFFFF_FFFC);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h8012_3456);
      chk("lh_wrap_en1", bus.dmem_en, 1);
      chk("lh_wrap_addr1", bus.dmem_addr, 32'h0000_0000);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'hABCD_EF7F);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("lh_wrap_wb_valid", bus.wb_valid, 1);
      chk("lh_wrap_wb_data", bus.wb_data, 32'h0000_7F80);
      next_cycle();

      // back-to-back aligned LW then LHU
      drive(1'b1, 3'b010, 32'h0000_0010, 5'd5, 1'b0, 32'h0);
      chk("b2b_addr0", bus.dmem_addr, 32'h0000_0010);
      next_cycle();
      drive(1'b1, 3'b101, 32'h0000_0016, 5'd6, 1'b0, 32'hDEAD_BEEF);
      chk("b2b_ready1", bus.req_ready, 1);
      chk("b2b_addr1", bus.dmem_addr, 32'h0000_0014);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'hCAFE_F00D);
      chk("b2b_wb0_valid", bus.wb_valid, 1);
      chk("b2b_wb0_data", bus.wb_data, 32'hDEAD_BEEF);
      chk("b2b_wb0_rd", bus.wb_rd, 5);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("b2b_wb1_valid", bus.wb_valid, 1);
      chk("b2b_wb1_data", bus.wb_data, 32'h0000_CAFE);
      chk("b2b_wb1_rd", bus.wb_rd, 6);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("b2b_pulse_end", bus.wb_valid, 0);
      next_cycle();

      // reset during BEAT1 discards the load
      drive(1'b1, 3'b010, 32'h0000_0060, 5'd14, 1'b0, 32'h0);
      next_cycle();
      rst = 1'b1;
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h1111_2222);
      chk("rstb1_ready", bus.req_ready, 0);
      chk("rstb1_dmem_en", bus.dmem_en, 0);
      next_cycle();
      rst = 1'b0;
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("rstb1_wb_valid", bus.wb_valid, 0);
      chk("rstb1_wb_data", bus.wb_data, 0);
      chk("rstb1_wb_rd", bus.wb_rd, 0);
      chk("rstb1_wb_err", bus.wb_err, 0);
      chk("rstb1_ready_after", bus.req_ready, 1);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("rstb1_no_late_wb", bus.wb_valid, 0);
      next_cycle();

      // flush in BEAT2 of misaligned LW; same-cycle request dropped
      drive(1'b1, 3'b010, 32'h0000_3002, 5'd10, 1'b0, 32'h0);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'hAAAA_BBBB);
      next_cycle();
      drive(1'b1, 3'b011, 32'h0000_0044, 5'd11, 1'b1, 32'hCCCC_DDDD);
      chk("fl_b2_dmem_en", bus.dmem_en, 0);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("fl_b2_wb_valid", bus.wb_valid, 0);
      chk("fl_b2_ready", bus.req_ready, 1);
      chk("fl_b2_dmem_en_after", bus.dmem_en, 0);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("fl_b2_no_late_wb", bus.wb_valid, 0);
      next_cycle();

      // flush on the edge an aligned load would complete
      drive(1'b1, 3'b010, 32'h0000_0050, 5'd13, 1'b0, 32'h0);
      next_cycle();
      drive(1'b1, 3'b010, 32'h0000_0070, 5'd15, 1'b1, 32'h1234_5678);
      chk("fl_b1_dmem_en", bus.dmem_en, 0);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("fl_b1_wb_valid", bus.wb_valid, 0);
      chk("fl_b1_ready", bus.req_ready, 1);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("fl_b1_dropped_req", bus.wb_valid, 0);
      next_cycle();

      // unsupported funct3 011
      drive(1'b1, 3'b011, 32'h0000_0041, 5'd12, 1'b0, 32'h0);
      chk("err_dmem_en", bus.dmem_en, 1);
      chk("err_dmem_addr", bus.dmem_addr, 32'h0000_0040);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h1234_5678);
      chk("err_single_beat_en", bus.dmem_en, 0);
      next_cycle();
      drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
      chk("err_wb_valid", bus.wb_valid, 1);
      chk("err_wb_err", bus.wb_err, 1);
      chk("err_wb_data", bus.wb_data, 0);
      chk("err_wb_rd", bus.wb_rd, 12);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
